// File: rtl/shift_pkg.sv
// Shared definitions for the iterative right-shift unit.
// Holds the default operand/count widths, Op encodings and the FSM state type.
// Imported by ror_iter and rr_stage.
package shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_stage.sv
// Single barrel stage: shifts data right by 2^k according to Op, or passes it through.
// Ports: data_i operand, k_i stage index, en_i stage enable (count bit k), op_i operation,
//        data_o result. Purely combinational; reserved Op and en_i = 0 both pass data unchanged.
module rr_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int KW    = 2
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [KW-1:0]    k_i,
  input  logic             en_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] data_o
);

  logic [CNT_W-1:0] amt;

  always_comb begin
    amt    = {{(CNT_W-1){1'b0}}, 1'b1} << k_i;
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        // Shifting the doubled word right leaves the rotated value in the low half.
        OP_ROR:  data_o = WIDTH'({data_i, data_i} >> amt);
        OP_SRL:  data_o = data_i >> amt;
        // Sign-extend to double width first so the shift pulls in copies of the MSB.
        OP_SRA:  data_o = WIDTH'({{WIDTH{data_i[WIDTH-1]}}, data_i} >> amt);
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/ror_iter.sv
// Iterative right rotate / logical / arithmetic shift, one count bit per cycle (start/busy/done).
// Ports: clk, rst (async high), start, In, Cnt, Op in; busy, done (1-cycle pulse), Out, err out.
// Optional ROR_EARLY_EXIT_EN: finish as soon as no higher count bits remain (default: fixed CNT_W+1).
module ror_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic             err
);

  localparam int KW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       op_q,    op_d;
  logic [KW-1:0]    k_q,     k_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             err_q,   err_d;

  logic [WIDTH-1:0] stage_out;
  logic             last;

  rr_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .KW    (KW)
  ) u_stage (
    .data_i (data_q),
    .k_i    (k_q),
    .en_i   (cnt_q[k_q]),
    .op_i   (op_q),
    .data_o (stage_out)
  );

`ifdef ROR_EARLY_EXIT_EN
  logic [CNT_W-1:0] rem;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    k_d     = k_q;
    out_d   = out_q;
    err_d   = err_q;

    last = (k_q == KW'(CNT_W-1));
`ifdef ROR_EARLY_EXIT_EN
    // Bits above the current stage all clear: this stage is the final one that can change data.
    rem  = cnt_q >> k_q;
    last = last || ((rem >> 1) == '0);
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          data_d  = In;
          cnt_d   = Cnt;
          op_d    = Op;
          k_d     = '0;
          err_d   = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        data_d = stage_out;
        k_d    = k_q + KW'(1);
        if (last) begin
          state_d = DONE;
          out_d   = stage_out;
          err_d   = (op_q == OP_RSV);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      k_q     <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      k_q     <= k_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign Out  = out_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ror_iter.sv
// Testbench for ror_iter: directed operations with hand-computed results.
// Driver pushes expected result/err/done-cycle into a queue; monitor pops on each done pulse.
// Also checks reset values, operand isolation during busy, err hold/clear and mid-op reset.
module tb_ror_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic [1:0]  Op;
  logic        busy;
  logic        done;
  logic [15:0] Out;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] out;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];

  ror_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .In    (In),
    .Cnt   (Cnt),
    .Op    (Op),
    .busy  (busy),
    .done  (done),
    .Out   (Out),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycles from the accepting edge to the done cycle.
  function automatic int lat(input logic [3:0] c);
`ifdef ROR_EARLY_EXIT_EN
    int steps = 1;
    for (int b = 0; b < 4; b++) if (c[b]) steps = b + 1;
    return steps + 1;
`else
    return 5;
`endif
  endfunction

  // Call at a negedge while the DUT is in IDLE or DONE.
  task automatic issue(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o,
                       input logic [15:0] eo, input logic ee, input bit push);
    exp_t e;
    start = 1'b1;
    In    = i;
    Cnt   = c;
    Op    = o;
    @(posedge clk);
    #1;
    start = 1'b0;
    In    = 16'($urandom);
    Cnt   = 4'($urandom);
    Op    = 2'($urandom);
    if (push) begin
      e.out = eo;
      e.err = ee;
      e.cyc = cyc + lat(c) - 1;
      q.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 30 cycles");
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = q.pop_front();
          chk("out", Out, e.out);
          chk("err", err, e.err);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    In    = '0;
    Cnt   = '0;
    Op    = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err",  err,  0);
    chk("rst_out",  Out,  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic operations.
    issue(16'h8001, 4'd1,  2'b00, 16'hC000, 1'b0, 1'b1); wait_done(); @(negedge clk);
    issue(16'h8001, 4'd4,  2'b01, 16'h0800, 1'b0, 1'b1); wait_done(); @(negedge clk);
    issue(16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 1'b1); wait_done(); @(negedge clk);
    issue(16'h1234, 4'd0,  2'b00, 16'h1234, 1'b0, 1'b1); wait_done(); @(negedge clk);
    issue(16'h1234, 4'd1,  2'b00, 16'h091A, 1'b0, 1'b1); wait_done(); @(negedge clk);
    issue(16'h0001, 4'd15, 2'b00, 16'h0002, 1'b0, 1'b1); wait_done(); @(negedge clk);

    // Back-to-back with start pulses during busy.
    issue(16'h00F0, 4'd4, 2'b00, 16'h000F, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; In = 16'hFFFF; Cnt = 4'hF; Op = 2'b01;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(16'h0001, 4'd8, 2'b00, 16'h0100, 1'b0, 1'b1);
    wait_done(); @(negedge clk);

    // Reserved Op: err set, Out = In; err holds in IDLE, clears on next start.
    issue(16'hABCD, 4'd3, 2'b11, 16'hABCD, 1'b1, 1'b1);
    wait_done();
    @(negedge clk); @(negedge clk);
    chk("err_hold", err, 1);
    issue(16'h00FF, 4'd2, 2'b01, 16'h003F, 1'b0, 1'b1);
    chk("err_clr", err, 0);
    chk("out_hold", Out, 16'hABCD);
    wait_done(); @(negedge clk);

    // Reset during SHIFT cycle 2: no done, everything back to reset values.
    issue(16'h8000, 4'd5, 2'b10, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("busy_shift", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err",  err,  0);
    chk("mid_rst_out",  Out,  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'hF000, 4'd4, 2'b10, 16'hFF00, 1'b0, 1'b1);
    wait_done();
    repeat (8) @(negedge clk);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
